modulo_entrada_numero_bcd: RTL and testbench

//  Parametrised keypad number-entry controller for the calculator datapath.

---
 rtl/modulo_entrada_numero_bcd.sv | 105 ++++++++++
 tb/tb_modulo_entrada_numero_bcd.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_entrada_numero_bcd.sv
// Keypad number-entry controller: edge-detected presses shift BCD digits into a DIGITS-wide register.
// Optional backspace key (0xB) is enabled by defining MODULO_ENTRADA_BACKSPACE_EN.
module modulo_entrada_numero_bcd #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  entry_en,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  done_ack,
    output logic [4*DIGITS-1:0]   number_out,
    output logic [CNT_W-1:0]      digit_count,
    output logic                  digit_strobe,
    output logic                  overflow,
    output logic                  done,
    output logic [3:0]            done_key
);
    localparam logic [1:0] WAIT_PRESS   = 2'd0;
    localparam logic [1:0] APPLY        = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;
    localparam logic [1:0] DONE         = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0] state;
    logic       key_prev;
    logic [3:0] key_q;
    logic       press;

    assign press = key_valid & ~key_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= WAIT_PRESS;
            key_prev     <= 1'b0;
            key_q        <= 4'h0;
            number_out   <= '0;
            digit_count  <= '0;
            digit_strobe <= 1'b0;
            overflow     <= 1'b0;
            done         <= 1'b0;
            done_key     <= 4'h0;
        end else begin
            key_prev     <= key_valid;
            digit_strobe <= 1'b0;
            case (state)
                WAIT_PRESS: begin
                    if (press && entry_en) begin
                        key_q <= key_code;
                        state <= APPLY;
                    end
                end
                // The latched key is applied regardless of entry_en at this point.
                APPLY: begin
                    state <= WAIT_RELEASE;
                    if (key_q <= 4'd9) begin
                        if (digit_count == CNT_MAX) begin
                            overflow <= 1'b1;
                        end else if (!(key_q == 4'd0 && digit_count == '0)) begin
                            number_out   <= {number_out[4*DIGITS-5:0], key_q};
                            digit_count  <= digit_count + CNT_ONE;
                            digit_strobe <= 1'b1;
                        end
                    end else if (key_q == 4'hA) begin
                        number_out   <= '0;
                        digit_count  <= '0;
                        overflow     <= 1'b0;
                        digit_strobe <= 1'b1;
                    end else if (key_q == 4'hB) begin
`ifdef MODULO_ENTRADA_BACKSPACE_EN
                        if (digit_count != '0) begin
                            number_out   <= {4'h0, number_out[4*DIGITS-1:4]};
                            digit_count  <= digit_count - CNT_ONE;
                            overflow     <= 1'b0;
                            digit_strobe <= 1'b1;
                        end
`endif
                    end else begin
                        done     <= 1'b1;
                        done_key <= key_q;
                        state    <= DONE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!key_valid) state <= WAIT_PRESS;
                end
                // Presses are ignored here; a press coinciding with the ack is dropped
                // because WAIT_RELEASE waits for that key to be released.
                DONE: begin
                    if (done_ack) begin
                        done        <= 1'b0;
                        number_out  <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                        state       <= WAIT_RELEASE;
                    end
                end
                default: state <= WAIT_PRESS;
            endcase
        end
    end
endmodule

// File: tb/tb_modulo_entrada_numero_bcd.sv
// Directed bench for modulo_entrada_numero_bcd: DIGITS=4 and DIGITS=6 instances share one key stream,
// a reference model queues the expected value of every display strobe.
module tb_modulo_entrada_numero_bcd;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic entry_en = 1'b1;
    logic key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic done_ack = 1'b0;

    logic [15:0] n4;
    logic [2:0]  c4;
    logic        s4, o4, d4;
    logic [3:0]  k4;
    logic [23:0] n6;
    logic [2:0]  c6;
    logic        s6, o6, d6;
    logic [3:0]  k6;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [23:0] n;
        int          c;
    } exp_t;
    exp_t q4[$];
    exp_t q6[$];

    logic [23:0] m_n[2];
    int          m_cnt[2];
    logic        m_ovf[2];
    logic        m_done[2];
    logic [3:0]  m_dk[2];

    always #5 clk = ~clk;

    modulo_entrada_numero_bcd #(.DIGITS(4), .CNT_W(3)) dut4 (
        .clk(clk), .reset(reset), .entry_en(entry_en), .key_valid(key_valid),
        .key_code(key_code), .done_ack(done_ack), .number_out(n4), .digit_count(c4),
        .digit_strobe(s4), .overflow(o4), .done(d4), .done_key(k4));

    modulo_entrada_numero_bcd #(.DIGITS(6), .CNT_W(3)) dut6 (
        .clk(clk), .reset(reset), .entry_en(entry_en), .key_valid(key_valid),
        .key_code(key_code), .done_ack(done_ack), .number_out(n6), .digit_count(c6),
        .digit_strobe(s6), .overflow(o6), .done(d6), .done_key(k6));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_done[i] = 1'b0; m_dk[i] = 4'h0;
        end
        q4.delete();
        q6.delete();
    endtask

    task automatic model_key(input int i, input logic [3:0] c, output logic stb);
        int d;
        logic [23:0] mask;
        exp_t e;
        d = (i == 0) ? 4 : 6;
        mask = (i == 0) ? 24'h00FFFF : 24'hFFFFFF;
        stb = 1'b0;
        if (!entry_en || m_done[i]) return;
        if (c <= 4'd9) begin
            if (m_cnt[i] == d) m_ovf[i] = 1'b1;
            else if (!(c == 4'd0 && m_cnt[i] == 0)) begin
                m_n[i] = ((m_n[i] << 4) | {20'h0, c}) & mask;
                m_cnt[i]++;
                stb = 1'b1;
            end
        end else if (c == 4'hA) begin
            m_n[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0; stb = 1'b1;
        end else if (c == 4'hB) begin
`ifdef MODULO_ENTRADA_BACKSPACE_EN
            if (m_cnt[i] > 0) begin
                m_n[i] = m_n[i] >> 4; m_cnt[i]--; m_ovf[i] = 1'b0; stb = 1'b1;
            end
`endif
        end else begin
            m_done[i] = 1'b1; m_dk[i] = c;
        end
        if (stb) begin
            e.n = m_n[i]; e.c = m_cnt[i];
            if (i == 0) q4.push_back(e); else q6.push_back(e);
        end
    endtask

    // Every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && s4) begin
            if (q4.size() == 0) check("strobe4_unexpected", 32'(q4.size()), 32'd1);
            else begin
                e = q4.pop_front();
                check("strobe4_num", {16'h0, n4}, {8'h0, e.n});
                check("strobe4_cnt", {29'h0, c4}, 32'(e.c));
            end
        end
        if (reset && s6) begin
            if (q6.size() == 0) check("strobe6_unexpected", 32'(q6.size()), 32'd1);
            else begin
                e = q6.pop_front();
                check("strobe6_num", {8'h0, n6}, {8'h0, e.n});
                check("strobe6_cnt", {29'h0, c6}, 32'(e.c));
            end
        end
    end

    task automatic chk_all(input string tag);
        check({tag, "_num4"}, {16'h0, n4}, {8'h0, m_n[0]});
        check({tag, "_cnt4"}, {29'h0, c4}, 32'(m_cnt[0]));
        check({tag, "_ovf4"}, {31'h0, o4}, {31'h0, m_ovf[0]});
        check({tag, "_done4"}, {31'h0, d4}, {31'h0, m_done[0]});
        check({tag, "_key4"}, {28'h0, k4}, {28'h0, m_dk[0]});
        check({tag, "_q4"}, 32'(q4.size()), 32'd0);
        check({tag, "_num6"}, {8'h0, n6}, {8'h0, m_n[1]});
        check({tag, "_cnt6"}, {29'h0, c6}, 32'(m_cnt[1]));
        check({tag, "_ovf6"}, {31'h0, o6}, {31'h0, m_ovf[1]});
        check({tag, "_done6"}, {31'h0, d6}, {31'h0, m_done[1]});
        check({tag, "_q6"}, 32'(q6.size()), 32'd0);
    endtask

    // Press a key, verify the 2-edge latency on the DIGITS=6 instance, hold, release.
    task automatic press_key(input logic [3:0] c, input int hold);
        logic stb4, stb6;
        @(posedge clk); #1;
        key_code = c; key_valid = 1'b1;
        model_key(0, c, stb4);
        model_key(1, c, stb6);
        @(posedge clk); #1;
        check("lat_edge1_strobe6", {31'h0, s6}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge2_strobe6", {31'h0, s6}, {31'h0, stb6});
        repeat (hold) @(posedge clk);
        #1 key_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        done_ack = 1'b1;
        for (int i = 0; i < 2; i++)
            if (m_done[i]) begin
                m_done[i] = 1'b0; m_n[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end
        @(posedge clk); #1;
        done_ack = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        model_reset();
        #12;
        chk_all("reset");
        check("reset_strobe4", {31'h0, s4}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Reset during APPLY: no partial update survives.
        press_key(4'h1, 1);
        press_key(4'h2, 1);
        @(posedge clk); #1;
        key_code = 4'h3; key_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; key_valid = 1'b0;
        model_reset();
        #1 chk_all("mid_apply_reset");
        @(posedge clk); #1 reset = 1'b1;

        press_key(4'h1, 1); press_key(4'h2, 1); press_key(4'h3, 1);
        #1 chk_all("keys123");
        check("keys123_num", {16'h0, n4}, 32'h0123);

        press_key(4'hA, 1);
        press_key(4'h0, 1); press_key(4'h0, 1); press_key(4'h5, 1);
        #1 chk_all("leading_zero");
        check("leading_zero_num", {16'h0, n4}, 32'h0005);

        press_key(4'hA, 1);
        for (int k = 1; k <= 5; k++) press_key(4'(k), 1);
        #1 chk_all("overflow4");
        check("overflow4_num", {16'h0, n4}, 32'h1234);
        press_key(4'h6, 1); press_key(4'h7, 1);
        #1 chk_all("overflow6");
        check("overflow6_num", {8'h0, n6}, 32'h123456);
        press_key(4'hA, 1);
        #1 chk_all("clear");

        press_key(4'h7, 20);
        #1 chk_all("held_key");
        entry_en = 1'b0;
        press_key(4'h8, 1);
        entry_en = 1'b1;
        #1 chk_all("entry_disabled");

        // done_ack outside DONE has no effect.
        ack();
        chk_all("stray_ack");

        press_key(4'hA, 1);
        press_key(4'h4, 1); press_key(4'h2, 1); press_key(4'hF, 1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("done_hold", {31'h0, d4}, 32'd1);
        end
        press_key(4'h9, 1);
        #1 chk_all("done_state");
        check("done_num", {16'h0, n4}, 32'h0042);
        ack();
        chk_all("after_ack");

        // Ack with a simultaneous press: the press is discarded.
        press_key(4'h6, 1); press_key(4'hC, 1);
        @(posedge clk); #1;
        done_ack = 1'b1; key_code = 4'h3; key_valid = 1'b1;
        m_done[0] = 1'b0; m_n[0] = '0; m_cnt[0] = 0; m_ovf[0] = 1'b0;
        m_done[1] = 1'b0; m_n[1] = '0; m_cnt[1] = 0; m_ovf[1] = 1'b0;
        @(posedge clk); #1 done_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all("ack_press");

        press_key(4'hB, 1);
        #1 chk_all("bksp_empty");
        press_key(4'h9, 1); press_key(4'h8, 1); press_key(4'hB, 1);
        #1 chk_all("bksp");
`ifdef MODULO_ENTRADA_BACKSPACE_EN
        check("bksp_num", {16'h0, n4}, 32'h0009);
`else
        check("bksp_num", {16'h0, n4}, 32'h0098);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
